fifo_burst_reader: RTL and testbench

Downstream drain stage for the single-clock showahead FIFO. Pops words from the FIFO read port and presents them as a valid/ready stream with start/end-of-packet framing. Words are grouped into fixed-length bursts, and a timeout flushes a short burst when the FIFO stalls below the burst threshold. A 2-entry output skid buffer keeps `fifo_rdreq_o` free of any combinational path from `ready_i`.

---
 rtl/fifo_burst_pkg.sv | 25 ++
 rtl/stream_skid_buf.sv | 77 +++++++
 rtl/fifo_burst_reader.sv | 135 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst drain stage and its output skid buffer.
package fifo_burst_pkg;

  // Drain FSM states: waiting for a trigger, draining a full burst, draining a short one.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Packet framing carried alongside every data word.
  typedef struct packed {
    logic sop;
    logic eop;
  } frame_t;

  // Number of entries in the output skid buffer.
  localparam int unsigned SKID_DEPTH = 2;

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer of {data, frame}; the head entry drives the stream outputs.
module stream_skid_buf
  import fifo_burst_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 5
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  frame_t            push_frame_i,
  input  logic              pop_i,
  output logic [OWIDTH-1:0] occ_o,
  output logic              head_valid_o,
  output logic [DWIDTH-1:0] head_data_o,
  output frame_t            head_frame_o
);

  // Entry layout is sized here because the data width is only known per instance.
  typedef struct packed {
    logic [DWIDTH-1:0] data;
    frame_t            frame;
  } entry_t;

  localparam logic [OWIDTH-1:0] OCC_FULL = OWIDTH'(SKID_DEPTH);
  localparam logic [OWIDTH-1:0] OCC_ZERO = '0;

  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  logic [OWIDTH-1:0] occ_q, occ_d;
  logic [OWIDTH-1:0] occ_kept;
  logic              pop_eff;
  logic              push_eff;

  // Pop shifts the tail forward; a push lands in the first slot left free after the pop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    head_d   = head_q;
    tail_d   = tail_q;
    pop_eff  = pop_i && (occ_q != OCC_ZERO);
    occ_kept = occ_q - {{(OWIDTH-1){1'b0}}, pop_eff};
    push_eff = push_i && (occ_kept < OCC_FULL);
    if (pop_eff) begin
      head_d = tail_q;
    end
    if (push_eff) begin
      if (occ_kept == OCC_ZERO) begin
        head_d = '{data: push_data_i, frame: push_frame_i};
      end else begin
        tail_d = '{data: push_data_i, frame: push_frame_i};
      end
    end
    occ_d = occ_kept + {{(OWIDTH-1){1'b0}}, push_eff};
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      // NOTE: the storage entries are reset too, because the head is visible on data_o straight out of reset.
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o        = occ_q;
  assign head_valid_o = (occ_q != OCC_ZERO);
  assign head_data_o  = head_q.data;
  assign head_frame_o = head_q.frame;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a showahead FIFO into a framed valid/ready stream in fixed-length bursts,
// flushing a short burst when the FIFO sits below the burst threshold for too long.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DWIDTH        = 32,
  parameter int AWIDTH        = 4,
  parameter int BURST_LEN     = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int              CW         = AWIDTH + 1;
  localparam int              ICW        = cnt_width(FLUSH_TIMEOUT);
  localparam bit              FLUSH_EN   = (FLUSH_TIMEOUT != 0);
  localparam logic [CW-1:0]   BURST_LEN_C = CW'(BURST_LEN);
  localparam logic [CW-1:0]   ONE_C      = CW'(1);
  localparam logic [CW-1:0]   SKID_FULL  = CW'(SKID_DEPTH);
  localparam logic [ICW-1:0]  IDLE_LAST  = ICW'(FLUSH_EN ? FLUSH_TIMEOUT - 1 : 0);
  localparam logic [ICW-1:0]  IDLE_SAT   = ICW'(FLUSH_EN ? FLUSH_TIMEOUT : 0);

  logic [1:0]     rst_sync_q;
  logic           rst_n;
  state_t         state_q, state_d;
  logic [CW-1:0]  remain_q, remain_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
  logic           sop_pend_q, sop_pend_d;
  logic           rdreq;
  frame_t         push_frame;
  frame_t         head_frame;
  logic [CW-1:0]  occ;

  // Reset asserts asynchronously and releases two edges later, in step with clk_i.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  // Next-state, burst counters and the pop decision.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    idle_cnt_d = idle_cnt_q;
    sop_pend_d = sop_pend_q;
    rdreq      = 1'b0;
    push_frame = '0;
    unique case (state_q)
      IDLE: begin
        if (fifo_usedw_i >= BURST_LEN_C) begin
          state_d    = BURST;
          remain_d   = BURST_LEN_C;
          sop_pend_d = 1'b1;
          idle_cnt_d = '0;
        end else if (FLUSH_EN && (idle_cnt_q == IDLE_LAST) && !fifo_empty_i) begin
          // usedw is a safe lower bound: only our own pops can shrink it.
          state_d    = FLUSH;
          remain_d   = fifo_usedw_i;
          sop_pend_d = 1'b1;
          idle_cnt_d = '0;
        end else if (fifo_empty_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_SAT) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      BURST, FLUSH: begin
        // Depends only on registered occupancy, never on ready_i.
        rdreq = !fifo_empty_i && (occ < SKID_FULL);
        if (rdreq) begin
          remain_d       = remain_q - 1'b1;
          sop_pend_d     = 1'b0;
          push_frame.sop = sop_pend_q;
          push_frame.eop = (remain_q == ONE_C);
          if (remain_q == ONE_C) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      idle_cnt_q <= '0;
      sop_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      idle_cnt_q <= idle_cnt_d;
      sop_pend_q <= sop_pend_d;
    end
  end

  stream_skid_buf #(
    .DWIDTH(DWIDTH),
    .OWIDTH(CW)
  ) u_skid (
    .clk_i        (clk_i),
    .arst_n_i     (rst_n),
    .push_i       (rdreq),
    .push_data_i  (fifo_q_i),
    .push_frame_i (push_frame),
    .pop_i        (valid_o && ready_i),
    .occ_o        (occ),
    .head_valid_o (valid_o),
    .head_data_o  (data_o),
    .head_frame_o (head_frame)
  );

  assign fifo_rdreq_o = rdreq;
  assign sop_o        = head_frame.sop;
  assign eop_o        = head_frame.eop;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: bench-owned showahead FIFO model, directed timing
// sequences, and a table of burst scenarios checked beat by beat.
module tb_fifo_burst_reader;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BL    = 4;
  localparam int FT    = 16;
  localparam int DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          arst_n_i = 1'b0;
  logic [DW-1:0] fifo_q_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic [AW:0]   fifo_usedw_i = '0;
  logic          fifo_rdreq_o;
  logic [DW-1:0] data_o;
  logic          valid_o, sop_o, eop_o, busy_o;
  logic          ready_i = 1'b1;

  always #5 clk_i = ~clk_i;

  fifo_burst_reader #(
    .DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_usedw_i (fifo_usedw_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    int            preload;
    int            stream;
    logic [DW-1:0] base;
    bit            toggle;
  } vec_t;

  logic [DW-1:0] fifo_m[$];
  logic [DW-1:0] wr_q[$];
  beat_t         rx_q[$];
  int            occ_m;
  bit            toggle_mode;
  bit            prev_stall;
  beat_t         prev_beat;
  int            n_checks;
  int            n_fail;
  vec_t          vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fifo_m.size() == 0);
    fifo_q_i     = (fifo_m.size() != 0) ? fifo_m[0] : '0;
    fifo_usedw_i = (AW+1)'(fifo_m.size());
  endtask

  // One clock: sample mid-cycle, advance the FIFO model after the edge, end on the falling edge.
  task automatic tick();
    bit            pop_now;
    bit            xfer_now;
    bit            can_wr;
    beat_t         b;
    logic [DW-1:0] tmp;
    #1;
    pop_now  = fifo_rdreq_o;
    xfer_now = valid_o && ready_i;
    if (pop_now) begin
      check("rdreq_while_empty", 64'(fifo_m.size() == 0), 64'd0);
      check("rdreq_with_skid_full", 64'(occ_m >= 2), 64'd0);
    end
    if (arst_n_i && valid_o && prev_stall) begin
      check("hold_data", 64'(data_o), 64'(prev_beat.data));
      check("hold_sop", 64'(sop_o), 64'(prev_beat.sop));
      check("hold_eop", 64'(eop_o), 64'(prev_beat.eop));
    end
    b.data = data_o;
    b.sop  = sop_o;
    b.eop  = eop_o;
    prev_stall = arst_n_i && valid_o && !ready_i;
    prev_beat  = b;
    if (xfer_now) rx_q.push_back(b);
    can_wr = (fifo_m.size() < DEPTH);
    @(posedge clk_i);
    #1;
    if (!arst_n_i) begin
      occ_m = 0;
    end else begin
      if (pop_now) tmp = fifo_m.pop_front();
      occ_m = occ_m + int'(pop_now) - int'(xfer_now);
    end
    if (can_wr && wr_q.size() > 0) fifo_m.push_back(wr_q.pop_front());
    ready_i = toggle_mode ? ~ready_i : 1'b1;
    drive_fifo();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    arst_n_i    = 1'b0;
    toggle_mode = 1'b0;
    ready_i     = 1'b1;
    prev_stall  = 1'b0;
    occ_m       = 0;
    fifo_m.delete();
    wr_q.delete();
    rx_q.delete();
    drive_fifo();
    repeat (2) tick();
    arst_n_i = 1'b1;
    repeat (3) tick();
  endtask

  // Full bursts come first; any remainder leaves as one short flush burst.
  function automatic bit exp_sop(input int i, input int n);
    int full = n - (n % BL);
    if (i < full) return (i % BL) == 0;
    return i == full;
  endfunction

  function automatic bit exp_eop(input int i, input int n);
    int full = n - (n % BL);
    if (i < full) return (i % BL) == BL - 1;
    return i == n - 1;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int budget;
    n = v.preload + v.stream;
    do_reset();
    toggle_mode = v.toggle;
    for (int i = 0; i < v.preload; i++) fifo_m.push_back(v.base + DW'(i));
    for (int i = 0; i < v.stream; i++) wr_q.push_back(v.base + DW'(v.preload + i));
    drive_fifo();
    budget = 0;
    while (rx_q.size() < n && budget < 3000) begin
      tick();
      budget++;
    end
    repeat (30) tick();
    check($sformatf("v%0d_beat_count", idx), 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < rx_q.size() && i < n; i++) begin
      check($sformatf("v%0d_data%0d", idx, i), 64'(rx_q[i].data), 64'(v.base + DW'(i)));
      check($sformatf("v%0d_sop%0d", idx, i), 64'(rx_q[i].sop), 64'(exp_sop(i, n)));
      check($sformatf("v%0d_eop%0d", idx, i), 64'(rx_q[i].eop), 64'(exp_eop(i, n)));
    end
    check($sformatf("v%0d_busy_end", idx), 64'(busy_o), 64'd0);
    check($sformatf("v%0d_fifo_drained", idx), 64'(fifo_m.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{preload: 0,  stream: 4,  base: 32'h0000_00A0, toggle: 1'b0};
    vecs[1] = '{preload: 8,  stream: 0,  base: 32'h0000_00B0, toggle: 1'b1};
    vecs[2] = '{preload: 0,  stream: 3,  base: 32'h0000_00C0, toggle: 1'b0};
    vecs[3] = '{preload: 0,  stream: 1,  base: 32'h0000_00D0, toggle: 1'b0};
    vecs[4] = '{preload: 15, stream: 21, base: 32'h0000_0100, toggle: 1'b0};
    vecs[5] = '{preload: 0,  stream: 6,  base: 32'h0000_00E0, toggle: 1'b1};
    vecs[6] = '{preload: 9,  stream: 0,  base: 32'h0000_00F0, toggle: 1'b0};

    @(negedge clk_i);
    // Reset values while reset is held.
    repeat (2) tick();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_sop", 64'(sop_o), 64'd0);
    check("rst_eop", 64'(eop_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rdreq", 64'(fifo_rdreq_o), 64'd0);

    // Decision-to-output latency and 1 word/cycle throughput.
    do_reset();
    for (int i = 0; i < 4; i++) fifo_m.push_back(32'hA0 + DW'(i));
    drive_fifo();
    check("lat_busy_n", 64'(busy_o), 64'd0);
    tick();
    check("lat_busy_n1", 64'(busy_o), 64'd1);
    check("lat_rdreq_n1", 64'(fifo_rdreq_o), 64'd1);
    check("lat_valid_n1", 64'(valid_o), 64'd0);
    tick();
    check("lat_valid_n2", 64'(valid_o), 64'd1);
    check("lat_sop_n2", 64'(sop_o), 64'd1);
    check("lat_data_n2", 64'(data_o), 64'hA0);
    tick();
    check("lat_data_n3", 64'(data_o), 64'hA1);
    check("lat_sop_n3", 64'(sop_o), 64'd0);
    tick();
    check("lat_data_n4", 64'(data_o), 64'hA2);
    check("lat_rdreq_n4", 64'(fifo_rdreq_o), 64'd1);
    tick();
    check("lat_data_n5", 64'(data_o), 64'hA3);
    check("lat_eop_n5", 64'(eop_o), 64'd1);
    check("lat_busy_n5", 64'(busy_o), 64'd0);
    check("lat_rdreq_n5", 64'(fifo_rdreq_o), 64'd0);
    tick();
    check("lat_valid_n6", 64'(valid_o), 64'd0);
    check("lat_fifo_empty", 64'(fifo_m.size()), 64'd0);

    // Flush fires after the 16th consecutive non-empty idle cycle.
    do_reset();
    for (int i = 0; i < 3; i++) fifo_m.push_back(32'hC0 + DW'(i));
    drive_fifo();
    repeat (15) tick();
    check("flush_busy_15", 64'(busy_o), 64'd0);
    tick();
    check("flush_busy_16", 64'(busy_o), 64'd1);
    check("flush_rdreq_16", 64'(fifo_rdreq_o), 64'd1);
    tick();
    check("flush_valid_17", 64'(valid_o), 64'd1);
    check("flush_sop_17", 64'(sop_o), 64'd1);
    check("flush_data_17", 64'(data_o), 64'hC0);
    repeat (2) tick();
    check("flush_data_19", 64'(data_o), 64'hC2);
    check("flush_eop_19", 64'(eop_o), 64'd1);
    check("flush_sop_19", 64'(sop_o), 64'd0);

    // Asynchronous reset after the second beat of a burst.
    do_reset();
    for (int i = 0; i < 8; i++) fifo_m.push_back(32'h50 + DW'(i));
    drive_fifo();
    budget = 0;
    while (rx_q.size() < 2 && budget < 50) begin
      tick();
      budget++;
    end
    check("mid_two_beats", 64'(rx_q.size()), 64'd2);
    arst_n_i = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_rdreq", 64'(fifo_rdreq_o), 64'd0);
    check("mid_fifo_head", 64'((fifo_m.size() != 0) ? fifo_m[0] : '0), 64'h53);
    rx_q.delete();
    prev_stall = 1'b0;
    repeat (2) tick();
    arst_n_i = 1'b1;
    budget = 0;
    while (rx_q.size() < 4 && budget < 100) begin
      tick();
      budget++;
    end
    check("mid_after_count", 64'(rx_q.size()), 64'd4);
    if (rx_q.size() >= 4) begin
      check("mid_after_data0", 64'(rx_q[0].data), 64'h53);
      check("mid_after_sop0", 64'(rx_q[0].sop), 64'd1);
      check("mid_after_data3", 64'(rx_q[3].data), 64'h56);
      check("mid_after_eop3", 64'(rx_q[3].eop), 64'd1);
    end

    // Table of burst scenarios.
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
